counter_nbit: RTL and testbench
===============================

# counter_nbit

Parametrised up/down counter for the counter family, generalising the 4-bit load/enable counter to arbitrary width and modulus. It adds direction control, a selectable wrap or saturate mode at the range bounds, a registered terminal-event pulse and a sticky event flag. Intended as the standard event/tick counter for timers, address generators and testbench stimulus in the design.

## Interface

Parameters:

- `WIDTH`, 8: counter width in bits; legal 2..32.
- `MAX_VAL`, 2**WIDTH-1: upper bound of the count range 0..MAX_VAL; legal 1..2**WIDTH-1.
- `SATURATE`, 0: 0 means wrap at the bounds, 1 means hold at the bounds.

Ports:

- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `enable`  in  1  count one step in the direction given by `up` this cycle.
- `load`  in  1  synchronous parallel load of `cnt_in`.
- `cnt_in`  in  WIDTH  load value.
- `up`  in  1  direction: 1 counts up, 0 counts down.
- `flag_clr`  in  1  clears `flag`.
- `cnt`  out  WIDTH  current count (registered).
- `tc`  out  1  one-cycle pulse, registered: the previous edge produced a wrap or saturation event.
- `flag`  out  1  sticky event flag (registered).

## Operation

- Priority per edge: `reset` > `load` > `enable`. With none asserted, all state holds and `tc` is 0.
- Reset: `cnt`=0, `tc`=0, `flag`=0.
- Load: `cnt` <= min(`cnt_in`, MAX_VAL), so out-of-range values clamp to MAX_VAL. `tc`=0. The flag is unaffected, apart from `flag_clr`. A load overrides `enable` in the same cycle.
- Enable with up=1:
  - cnt < MAX_VAL: increment.
  - cnt == MAX_VAL, wrap mode: go to 0 and set `tc`.
  - cnt == MAX_VAL, saturate mode: hold at MAX_VAL and set `tc` (saturation event).
- Enable with up=0:
  - cnt > 0: decrement.
  - cnt == 0, wrap mode: go to MAX_VAL and set `tc`.
  - cnt == 0, saturate mode: hold at 0 and set `tc`.
- Saturate mode, repeated enable at a bound: `tc` pulses on every such edge, so it stays high while the counter is pinned.
- Flag update:
  - Set on any edge that sets `tc`.
  - Cleared by `flag_clr`.
  - Set and clear on the same edge: set wins.
- Direction may change on any cycle. No extra latency, no glitch state.
- Arithmetic: all bounds comparisons are unsigned at WIDTH bits. When MAX_VAL = 2**WIDTH-1, natural binary overflow must give the same result as an explicit compare.

## Timing

- Latency:
  - `cnt` reflects a load or step one edge after the controlling inputs.
  - `tc` and `flag` update on the same edge as `cnt`.
- Reset mid-count, including in the same cycle as load, enable or an event: reset wins and all outputs are 0 after that edge.
- No combinational path from any input to any output.
- Single clock domain; inputs must be synchronous to `clock`.

## Structure

- Shared package `counter_pkg`:
  - mode constants `CNT_WRAP`=0 and `CNT_SAT`=1.
  - a width-checking function used for elaboration-time assertions on WIDTH and MAX_VAL.
- One combinational sub-module, `counter_step`:
  - inputs: current count, `up`, mode, MAX_VAL.
  - outputs: next count and an event bit.
- The top level holds the registers, the priority mux and the flag logic.

## Test plan

- Reset/load clamp: WIDTH=4, MAX_VAL=9, wrap. Reset, then load 12 -> `cnt`=9. Enable with up=1 -> `cnt`=0, `tc`=1 for one cycle, `flag`=1.
- Down-wrap: WIDTH=4, MAX_VAL=9. Load 1, then enable with up=0 for 2 cycles -> `cnt` 0 then 9; `tc` high only on the second result.
- Saturate: WIDTH=8, SATURATE=1. Load 254, then 3 up steps -> `cnt` 255, 255, 255; `tc` 0, 1, 1. Then up=0 for 1 step -> `cnt`=254 and `tc`=0.
- Priority: assert `load` (`cnt_in`=5) and `enable` together -> `cnt`=5. Assert `reset`, `load` and `enable` together -> `cnt`=0, `flag`=0.
- Flag race: with `flag`=0 and `cnt`=MAX_VAL, assert enable (up=1) and `flag_clr` on the same cycle -> `flag`=1. Next cycle `flag_clr` alone -> `flag`=0.
- Full-range wrap: WIDTH=8 at default parameters, 256 consecutive up steps from 0 -> `cnt` back to 0; `tc` exactly once, on the final step.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared definitions for the counter family: end-of-range modes and
// parameter legality checking used at elaboration.
package counter_pkg;

  localparam int unsigned CNT_WRAP = 0;
  localparam int unsigned CNT_SAT  = 1;

  // True when width is 2..32 and max_val lies in 1..2**width-1.
  function automatic bit params_ok(input int unsigned width, input longint unsigned max_val);
    longint unsigned limit;
    if (width < 2 || width > 32) return 1'b0;
    limit = (64'd1 << width) - 64'd1;
    return (max_val >= 64'd1) && (max_val <= limit);
  endfunction

endpackage

// File: rtl/counter_step.sv
// Combinational single-step of the counter: next value for one up/down
// step within 0..max_val, plus an event bit on a wrap or saturation.
module counter_step #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] cnt,
  input  logic             up,
  input  logic             sat_mode,
  input  logic [WIDTH-1:0] max_val,
  output logic [WIDTH-1:0] cnt_next_c,
  output logic             event_c
);

  // Explicit bound compares keep wrap at MAX_VAL independent of binary overflow.
  always_comb begin
    cnt_next_c = cnt;
    event_c    = 1'b0;
    if (up) begin
      if (cnt >= max_val) begin
        event_c    = 1'b1;
        cnt_next_c = sat_mode ? max_val : '0;
      end else begin
        cnt_next_c = cnt + WIDTH'(1);
      end
    end else begin
      if (cnt == '0) begin
        event_c    = 1'b1;
        cnt_next_c = sat_mode ? '0 : max_val;
      end else begin
        cnt_next_c = cnt - WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/counter_nbit.sv
// Parametrised up/down counter with load, wrap/saturate mode, registered
// terminal-event pulse and sticky event flag.
module counter_nbit
  import counter_pkg::*;
#(
  parameter int unsigned     WIDTH    = 8,
  parameter longint unsigned MAX_VAL  = (64'd1 << WIDTH) - 64'd1,
  parameter int unsigned     SATURATE = CNT_WRAP
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] cnt_in,
  input  logic             up,
  input  logic             flag_clr,
  output logic [WIDTH-1:0] cnt,
  output logic             tc,
  output logic             flag
);

  localparam logic [WIDTH-1:0] MAX_W    = WIDTH'(MAX_VAL);
  localparam logic             SAT_MODE = (SATURATE == CNT_SAT);

  if (!params_ok(WIDTH, MAX_VAL)) begin : g_bad_params
    $error("counter_nbit: illegal WIDTH/MAX_VAL combination");
  end

  logic [WIDTH-1:0] load_val_c;
  logic [WIDTH-1:0] step_val_c;
  logic             step_event_c;
  logic             flag_kept_c;

  counter_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .cnt        (cnt),
    .up         (up),
    .sat_mode   (SAT_MODE),
    .max_val    (MAX_W),
    .cnt_next_c (step_val_c),
    .event_c    (step_event_c)
  );

  // Out-of-range loads clamp to the top of the count range.
  assign load_val_c  = (cnt_in > MAX_W) ? MAX_W : cnt_in;
  assign flag_kept_c = flag & ~flag_clr;

  // Priority reset > load > enable; an event sets the flag even against flag_clr.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt  <= '0;
      tc   <= 1'b0;
      flag <= 1'b0;
    end else if (load) begin
      cnt  <= load_val_c;
      tc   <= 1'b0;
      flag <= flag_kept_c;
    end else if (enable) begin
      cnt  <= step_val_c;
      tc   <= step_event_c;
      flag <= step_event_c | flag_kept_c;
    end else begin
      tc   <= 1'b0;
      flag <= flag_kept_c;
    end
  end

endmodule

// File: tb/tb_counter_nbit.sv
// Bench for counter_nbit: three parameterisations share one directed stimulus
// stream and are checked every cycle against an arithmetic model.
module tb_counter_nbit;

  logic       clock = 1'b0;
  logic       reset, enable, load, up, flag_clr;
  logic [7:0] cnt_in;

  logic [3:0] cnt_a;
  logic [7:0] cnt_s, cnt_d;
  logic       tc_a, tc_s, tc_d, flag_a, flag_s, flag_d;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  // A: 4-bit, 0..9, wrap.  S: 8-bit saturate.  D: 8-bit defaults (wrap).
  counter_nbit #(.WIDTH(4), .MAX_VAL(9), .SATURATE(0)) dut_a (
    .clock(clock), .reset(reset), .enable(enable), .load(load), .cnt_in(cnt_in[3:0]),
    .up(up), .flag_clr(flag_clr), .cnt(cnt_a), .tc(tc_a), .flag(flag_a));

  counter_nbit #(.WIDTH(8), .SATURATE(1)) dut_s (
    .clock(clock), .reset(reset), .enable(enable), .load(load), .cnt_in(cnt_in),
    .up(up), .flag_clr(flag_clr), .cnt(cnt_s), .tc(tc_s), .flag(flag_s));

  counter_nbit dut_d (
    .clock(clock), .reset(reset), .enable(enable), .load(load), .cnt_in(cnt_in),
    .up(up), .flag_clr(flag_clr), .cnt(cnt_d), .tc(tc_d), .flag(flag_d));

  // Model state per instance.
  int  m_cnt [3];
  bit  m_tc  [3];
  bit  m_flag[3];
  int  m_max [3] = '{9, 255, 255};
  bit  m_sat [3] = '{1'b0, 1'b1, 1'b0};
  int  m_mod [3] = '{16, 256, 256};
  bit  model_valid = 1'b0;

  function automatic bit at_bound(int c, bit u, int mx);
    return u ? (c == mx) : (c == 0);
  endfunction

  function automatic int next_val(int c, bit u, int mx, bit sat);
    if (at_bound(c, u, mx) && sat) return c;
    return u ? (c + 1) % (mx + 1) : (c + mx) % (mx + 1);
  endfunction

  always @(posedge clock) begin
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        m_cnt[i] = 0; m_tc[i] = 0; m_flag[i] = 0;
      end else if (load) begin
        int v;
        v = int'(cnt_in) % m_mod[i];
        m_cnt[i]  = (v > m_max[i]) ? m_max[i] : v;
        m_tc[i]   = 0;
        m_flag[i] = m_flag[i] && !flag_clr;
      end else if (enable) begin
        bit ev;
        ev = at_bound(m_cnt[i], up, m_max[i]);
        m_cnt[i]  = next_val(m_cnt[i], up, m_max[i], m_sat[i]);
        m_tc[i]   = ev;
        m_flag[i] = ev || (m_flag[i] && !flag_clr);
      end else begin
        m_tc[i]   = 0;
        m_flag[i] = m_flag[i] && !flag_clr;
      end
    end
    model_valid = 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d", name, act, act, exp);
    end
  endtask

  // Per-cycle compare of every instance against the model.
  always @(negedge clock) begin
    if (model_valid) begin
      chk("a_state", {22'd0, cnt_a, tc_a, flag_a, 4'd0},
          {22'd0, 4'(m_cnt[0]), m_tc[0], m_flag[0], 4'd0});
      chk("s_state", {18'd0, cnt_s, tc_s, flag_s, 4'd0},
          {18'd0, 8'(m_cnt[1]), m_tc[1], m_flag[1], 4'd0});
      chk("d_state", {18'd0, cnt_d, tc_d, flag_d, 4'd0},
          {18'd0, 8'(m_cnt[2]), m_tc[2], m_flag[2], 4'd0});
    end
  end

  task automatic drive(input bit r, input bit en, input bit ld, input bit u,
                       input bit clr, input logic [7:0] val);
    reset = r; enable = en; load = ld; up = u; flag_clr = clr; cnt_in = val;
    @(posedge clock);
    #1;
  endtask

  int tc_seen;

  initial begin
    reset = 1'b1; enable = 1'b0; load = 1'b0; up = 1'b0; flag_clr = 1'b0; cnt_in = '0;

    drive(1, 0, 0, 0, 0, 8'd0);
    chk("reset_a_cnt", 32'(cnt_a), 0);
    chk("reset_flags", {30'd0, tc_a | tc_s | tc_d, flag_a | flag_s | flag_d}, 0);

    // Load clamp then up-wrap on A.
    drive(0, 0, 1, 0, 0, 8'd12);
    chk("load_clamp_a", 32'(cnt_a), 9);
    chk("load_d", 32'(cnt_d), 12);
    drive(0, 1, 0, 1, 0, 8'd0);
    chk("upwrap_a", {27'd0, cnt_a, tc_a}, {27'd0, 4'd0, 1'b1});
    chk("upwrap_flag_a", 32'(flag_a), 1);
    drive(0, 0, 0, 1, 0, 8'd0);
    chk("idle_tc_a", {30'd0, tc_a, flag_a}, {30'd0, 1'b0, 1'b1});

    // Down-wrap on A.
    drive(0, 0, 1, 0, 0, 8'd1);
    drive(0, 1, 0, 0, 0, 8'd0);
    chk("down1_a", {27'd0, cnt_a, tc_a}, {27'd0, 4'd0, 1'b0});
    drive(0, 1, 0, 0, 0, 8'd0);
    chk("down2_a", {27'd0, cnt_a, tc_a}, {27'd0, 4'd9, 1'b1});

    // Saturation on S.
    drive(0, 0, 1, 0, 0, 8'd254);
    chk("load_s", 32'(cnt_s), 254);
    drive(0, 1, 0, 1, 0, 8'd0);
    chk("sat1_s", {23'd0, cnt_s, tc_s}, {23'd0, 8'd255, 1'b0});
    drive(0, 1, 0, 1, 0, 8'd0);
    chk("sat2_s", {23'd0, cnt_s, tc_s}, {23'd0, 8'd255, 1'b1});
    drive(0, 1, 0, 1, 0, 8'd0);
    chk("sat3_s", {23'd0, cnt_s, tc_s}, {23'd0, 8'd255, 1'b1});
    drive(0, 1, 0, 0, 0, 8'd0);
    chk("sat_down_s", {23'd0, cnt_s, tc_s}, {23'd0, 8'd254, 1'b0});

    // Priority: load over enable, reset over everything.
    drive(0, 1, 1, 1, 0, 8'd5);
    chk("load_over_en", {8'd0, 4'd0, cnt_a, cnt_s, cnt_d}, {8'd0, 4'd0, 4'd5, 8'd5, 8'd5});
    drive(1, 1, 1, 1, 0, 8'd7);
    chk("reset_wins", {8'd0, 4'd0, cnt_a, cnt_s, cnt_d}, 0);
    chk("reset_wins_flag", {29'd0, flag_a, flag_s, flag_d}, 0);

    // Flag set/clear race on A.
    drive(0, 0, 1, 0, 0, 8'd9);
    drive(0, 1, 0, 1, 1, 8'd0);
    chk("race_set_wins", {30'd0, tc_a, flag_a}, {30'd0, 1'b1, 1'b1});
    drive(0, 0, 0, 1, 1, 8'd0);
    chk("race_clear", 32'(flag_a), 0);

    // Full-range wrap on D.
    drive(1, 0, 0, 0, 0, 8'd0);
    tc_seen = 0;
    for (int i = 0; i < 256; i++) begin
      drive(0, 1, 0, 1, 0, 8'd0);
      if (tc_d) tc_seen++;
    end
    chk("full_wrap_cnt_d", 32'(cnt_d), 0);
    chk("full_wrap_last_tc", 32'(tc_d), 1);
    chk("full_wrap_tc_count", 32'(tc_seen), 1);

    // Mixed direction changes, checked by the model only.
    drive(0, 1, 0, 0, 0, 8'd0);
    drive(0, 1, 0, 1, 0, 8'd0);
    drive(0, 1, 0, 0, 1, 8'd0);
    drive(0, 1, 0, 0, 0, 8'd0);
    drive(0, 0, 0, 0, 1, 8'd0);
    drive(0, 0, 0, 0, 0, 8'd0);

    @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
